// File: rtl/filter_feedforward_pkg.sv
// Shared constants for the 16-tap feedforward FIR: widths, coefficient table
// and the rounding helper used by the output stage.
package filter_feedforward_pkg;

   localparam int TAPS   = 16;
   localparam int COEF_W = 16;
   localparam int PROD_W = 32;
   localparam int ACC_W  = 36;

   // One guard bit above the accumulator so adding the rounding bias cannot wrap.
   localparam int RND_W  = ACC_W + 1;

   // Q1.15 coefficients; 0x0800 everywhere is a 16-point moving average, DC gain 1.0.
   localparam logic signed [COEF_W-1:0] COEF [TAPS] = '{default: 16'sh0800};

   function automatic logic signed [RND_W-1:0] round_bias(input int shift);
      logic signed [RND_W-1:0] one;
      one = RND_W'(1);
      return one <<< (shift - 1);
   endfunction

endpackage

// File: rtl/filter_feedforward_sat.sv
// Output stage: round half toward +inf, arithmetic shift, then clamp or wrap to DATA_W.
// Clamping is built only when FILTER_FEEDFORWARD_SAT_EN is defined.
module filter_feedforward_sat
   import filter_feedforward_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int OUT_SHIFT = 15
) (
   input  logic [ACC_W-1:0]  acc,
   output logic [DATA_W-1:0] y
);

   logic signed [RND_W-1:0] biased;
   logic signed [RND_W-1:0] r;

   assign biased = $signed({acc[ACC_W-1], acc}) + round_bias(OUT_SHIFT);
   assign r      = biased >>> OUT_SHIFT;

`ifdef FILTER_FEEDFORWARD_SAT_EN
   localparam logic signed [RND_W-1:0] MAX_V = RND_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [RND_W-1:0] MIN_V = RND_W'(-(2 ** (DATA_W - 1)));

   always_comb begin
      y = DATA_W'(r);
      if (r > MAX_V) begin
         y = DATA_W'(MAX_V);
      end else if (r < MIN_V) begin
         y = DATA_W'(MIN_V);
      end
   end
`else
   // Plain two's-complement wrap: keep the low DATA_W bits.
   always_comb begin
      y = DATA_W'(r);
   end
`endif

endmodule

// File: rtl/filter_feedforward.sv
// 16-tap direct-form FIR low-pass: delay line, parallel multipliers, adder,
// rounded output register. Saturation selected by FILTER_FEEDFORWARD_SAT_EN.
module filter_feedforward
   import filter_feedforward_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int OUT_SHIFT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] audio_in,
   output logic [DATA_W-1:0] audio_out
);

   logic signed [DATA_W-1:0] x [TAPS];
   logic signed [PROD_W-1:0] p [TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sum;
   logic [DATA_W-1:0]        y;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) begin
            x[k] <= '0;
         end
      end else begin
         x[0] <= $signed(audio_in);
         for (int k = 1; k < TAPS; k++) begin
            x[k] <= x[k-1];
         end
      end
   end

   // Operands are sign-extended to the product width so the multiply is exact.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) begin
            p[k] <= '0;
         end
      end else begin
         for (int k = 0; k < TAPS; k++) begin
            p[k] <= PROD_W'(x[k]) * PROD_W'(COEF[k]);
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         sum = sum + ACC_W'(p[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
      end else begin
         acc <= sum;
      end
   end

   filter_feedforward_sat #(
      .DATA_W    (DATA_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_sat (
      .acc (acc),
      .y   (y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         audio_out <= '0;
      end else begin
         audio_out <= y;
      end
   end

endmodule

// File: tb/tb_filter_feedforward.sv
// Bench for filter_feedforward: directed impulse/step/saturation runs, a looped
// sine with a mid-stream reset, and random samples against a convolution model.
module tb_filter_feedforward;

   localparam int DATA_W   = 16;
   localparam int TAPS     = 16;
   localparam int LAT      = 3;
   localparam int COEF_VAL = 2048;
   localparam int SINE_N   = 2048;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] audio_in = '0;
   logic [DATA_W-1:0] audio_out;
   logic [DATA_W-1:0] audio_out_s11;

   int checks = 0;
   int failures = 0;

   // Samples captured since the last release, newest first.
   int hist[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp11_q[$];
   int sine_tbl[SINE_N];

   always #5 clk = ~clk;

   filter_feedforward dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .audio_in  (audio_in),
      .audio_out (audio_out)
   );

   filter_feedforward #(.DATA_W(16), .OUT_SHIFT(11)) dut_s11 (
      .clk       (clk),
      .rst_n     (rst_n),
      .audio_in  (audio_in),
      .audio_out (audio_out_s11)
   );

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Output after the current edge: convolution of samples captured 3..18 edges ago.
   function automatic logic [DATA_W-1:0] ref_out(input int shift);
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < TAPS; k++) begin
         if (k + LAT < hist.size()) acc += longint'(hist[k+LAT]) * COEF_VAL;
      end
      r = (acc + (longint'(1) << (shift - 1))) >>> shift;
`ifdef FILTER_FEEDFORWARD_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      return r[DATA_W-1:0];
   endfunction

   task automatic step(input logic [DATA_W-1:0] din, input logic rst, input string tag);
      audio_in = din;
      rst_n    = rst;
      @(posedge clk);
      if (!rst) begin
         hist.delete();
      end else begin
         hist.push_front(int'($signed(din)));
         if (hist.size() > TAPS + LAT) void'(hist.pop_back());
      end
      exp_q.push_back(ref_out(15));
      exp11_q.push_back(ref_out(11));
      #1;
      check(tag, audio_out, exp_q.pop_front());
      check({tag, "_s11"}, audio_out_s11, exp11_q.pop_front());
   endtask

   initial begin
      for (int i = 0; i < SINE_N; i++) begin
         sine_tbl[i] = $rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * i / SINE_N));
      end

      // Reset held with a full-scale input, then three release edges still zero.
      for (int i = 0; i < 4; i++) begin
         step(16'h7FFF, 1'b0, "reset");
         check("reset_zero", audio_out, 16'h0000);
      end
      step(16'h7FFF, 1'b1, "release");
      step(16'h0000, 1'b1, "release");
      check("release_zero", audio_out, 16'h0000);
      step(16'h0000, 1'b1, "release");
      check("release_zero", audio_out, 16'h0000);

      // Impulse: 16 outputs of 0x0800 starting 3 edges after capture.
      step(16'h0000, 1'b0, "imp_rst");
      step(16'h7FFF, 1'b1, "impulse");
      for (int i = 1; i <= 20; i++) begin
         step(16'h0000, 1'b1, "impulse");
         if (i >= LAT && i < LAT + TAPS) check("impulse_tap", audio_out, 16'h0800);
         else check("impulse_off", audio_out, 16'h0000);
      end

      for (int i = 0; i < 24; i++) step(16'h1000, 1'b1, "step_pos");
      check("step_pos_settled", audio_out, 16'h1000);
`ifdef FILTER_FEEDFORWARD_SAT_EN
      check("sat_pos", audio_out_s11, 16'h7FFF);
`else
      check("wrap_pos", audio_out_s11, 16'h0000);
`endif
      for (int i = 0; i < 24; i++) step(16'h8000, 1'b1, "step_neg");
      check("step_neg_settled", audio_out, 16'h8000);
      for (int i = 0; i < 24; i++) step(16'hF000, 1'b1, "step_f000");
      check("step_f000_settled", audio_out, 16'hF000);
`ifdef FILTER_FEEDFORWARD_SAT_EN
      check("sat_neg", audio_out_s11, 16'h8000);
`else
      check("wrap_neg", audio_out_s11, 16'h0000);
`endif

      // Looped sine with a one-clock reset partway through the second lap.
      for (int i = 0; i < 2 * SINE_N; i++) begin
         if (i == SINE_N + 700) begin
            step(16'(sine_tbl[i % SINE_N]), 1'b0, "sine_rst");
            check("sine_rst_zero", audio_out, 16'h0000);
         end else begin
            step(16'(sine_tbl[i % SINE_N]), 1'b1, "sine");
            if (i > SINE_N + 700 && i <= SINE_N + 703) check("sine_flush_zero", audio_out, 16'h0000);
         end
      end

      // Random samples, extremes and occasional resets.
      for (int i = 0; i < 800; i++) begin
         logic [DATA_W-1:0] d;
         logic              r;
         case ($urandom_range(0, 7))
            0:       d = 16'h7FFF;
            1:       d = 16'h8000;
            default: d = 16'($urandom);
         endcase
         r = ($urandom_range(0, 99) != 0);
         step(d, r, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
